// File: rtl/mem_data_resp.sv
// Multi-cycle word RAM responder for the load/store path with valid/ready request and response.
// Define MEM_DATA_RESP_MISALIGN_EN to flag and suppress misaligned half/word accesses.
module mem_data_resp #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_load_code,
  input  logic [1:0]  req_store_code,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        wr;
  logic [AW+1:0] addr;
  logic [31:0] wdata;
  logic [2:0]  lcode;
  logic [1:0]  scode;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] widx;
  logic [31:0]   rd_word;
  logic [31:0]   wr_word;
  logic [31:0]   wsrc;
  logic [3:0]    be;
  logic [7:0]    lbyte;
  logic [15:0]   lhalf;
  logic [31:0]   ld_data;
  logic          err;
  logic          last;
  logic          mem_we;

  assign widx    = addr[AW+1:2];
  assign rd_word = mem[widx];
  assign last    = (state == StWait) && (cnt == 4'd0);
  assign mem_we  = last && wr && !err;

  always_comb begin
    err = 1'b0;
`ifdef MEM_DATA_RESP_MISALIGN_EN
    if (wr) begin
      case (scode)
        2'b01:   err = addr[0];
        2'b10:   err = |addr[1:0];
        default: err = 1'b0;
      endcase
    end else begin
      case (lcode)
        3'b000, 3'b100: err = 1'b0;
        3'b001, 3'b101: err = addr[0];
        default:        err = |addr[1:0];
      endcase
    end
`endif
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be   = 4'b0000;
    wsrc = wdata;
    case (scode)
      2'b00: begin
        be   = 4'b0001 << addr[1:0];
        wsrc = {4{wdata[7:0]}};
      end
      2'b01: begin
        be   = addr[1] ? 4'b1100 : 4'b0011;
        wsrc = {2{wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = be[i] ? wsrc[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  always_comb begin
    case (addr[1:0])
      2'b00:   lbyte = rd_word[7:0];
      2'b01:   lbyte = rd_word[15:8];
      2'b10:   lbyte = rd_word[23:16];
      default: lbyte = rd_word[31:24];
    endcase
    lhalf = addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (lcode)
      3'b000:  ld_data = {{24{lbyte[7]}}, lbyte};
      3'b001:  ld_data = {{16{lhalf[15]}}, lhalf};
      3'b100:  ld_data = {24'd0, lbyte};
      3'b101:  ld_data = {16'd0, lhalf};
      default: ld_data = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[widx] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      cnt        <= 4'd0;
      wr         <= 1'b0;
      addr       <= '0;
      wdata      <= 32'd0;
      lcode      <= 3'd0;
      scode      <= 2'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid) begin
            wr        <= req_wr;
            addr      <= req_addr[AW+1:0];
            wdata     <= req_wdata;
            lcode     <= req_load_code;
            scode     <= req_store_code;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= StWait;
          end
        end
        StWait: begin
          if (cnt == 4'd0) begin
            resp_rdata <= (wr || err) ? 32'd0 : ld_data;
            resp_err   <= err;
            resp_valid <= 1'b1;
            state      <= StResp;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= StIdle;
          end
        end
        default: begin
          state     <= StIdle;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_data_resp.md
Name: mem_data_resp

Overview:
Data-memory responder for the core's load/store path. It is the memory end of the data interface: it accepts one load or store request through a valid/ready handshake and models a LATENCY-cycle word-organised RAM. It returns sign- or zero-extended load data, or a store acknowledge, through a valid/ready response channel. It replaces the combinational data memory wherever the core or a testbench needs multi-cycle, back-pressured memory timing.

Parameters:
DEPTH, 1024, number of 32-bit words; power of 2; AW = log2(DEPTH)
LATENCY, 2, cycles from request acceptance to resp_valid; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_wr  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, LSB-aligned (byte in [7:0], half in [15:0])
req_load_code  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other values are treated as LW
req_store_code  input  2  00 SB, 01 SH, 10 SW; 11 = no write (ack only)
resp_valid  output  1  response present
resp_ready  input  1  requester accepts response
resp_rdata  output  32  extended load data; 0 for stores
resp_err  output  1  misaligned access (see Optional Feature)

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE; latency counter is 0.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - RAM contents are not reset.
- FSM states:
  - IDLE: req_ready=1, resp_valid=0. req_valid&&req_ready at a rising edge captures req_wr, req_addr, req_wdata and both codes, loads the counter with LATENCY-1, and moves to WAIT.
  - WAIT: req_ready=0. The counter decrements each cycle. On the edge where the counter is 0:
    - a store commits to RAM, or a load samples the RAM word;
    - resp_rdata and resp_err are registered;
    - the state moves to RESP.
  - RESP: resp_valid=1, req_ready=0. resp_rdata and resp_err hold stable until resp_valid&&resp_ready. On that edge the state goes to IDLE, resp_valid=0 and resp_rdata=0.
- Latency: with the request accepted at edge N, resp_valid is high after edge N+LATENCY. Minimum round trip with resp_ready held at 1 is LATENCY+1 cycles per transaction. There is no request pipelining.
- Addressing:
  - Word index = req_addr[AW+1:2]; addresses wrap modulo DEPTH*4.
  - Byte lane = addr[1:0].
  - Half lane = addr[1] (upper half when addr[1]=1).
- Stores (byte enables derived from store_code and lane):
  - SB writes wdata[7:0] to lane addr[1:0].
  - SH writes wdata[15:0] to the half selected by addr[1].
  - SW writes all 4 bytes.
  - Unwritten bytes keep their value.
- Loads:
  - The selected byte/half is shifted to the LSB.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Error: when resp_err=1, the store is suppressed (RAM unchanged) and resp_rdata=0.
- Simultaneous events: req_valid asserted in WAIT/RESP is ignored (not captured) and the requester must hold it. req_valid in the same cycle as the RESP handshake is not accepted until the next cycle (IDLE).
- Reset mid-operation: an access in WAIT is aborted and its store is not committed. An access already in RESP has completed its store, and the response is dropped.

Optional Feature:
MEM_DATA_RESP_MISALIGN_EN
- Defined: resp_err=1 when SH/LH/LHU has addr[0]=1, or SW/LW has addr[1:0]≠00; the access is suppressed as above.
- Undefined: resp_err is tied to 0. Low address bits below the access size are ignored: half accesses use addr[1] only, word accesses use the aligned word.

Test Plan:
- Reset then idle: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. With LATENCY=2, SW addr 0x10 data 0xDEADBEEF accepted at edge N -> resp_valid after edge N+2, resp_rdata=0.
- After that store, LW 0x10 -> 0xDEADBEEF. LB 0x13 -> 0xFFFFFFDE. LBU 0x13 -> 0x000000DE. LH 0x10 -> 0xFFFFBEEF. LHU 0x12 -> 0x0000DEAD.
- SB addr 0x11 data 0x00000055 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF. SH addr 0x12 data 0x1234, then LW 0x10 -> 0x123455EF.
- Back-pressure: hold resp_ready=0 for 5 cycles during a load -> resp_valid and resp_rdata stay stable and req_ready=0. Release -> next request accepted one cycle later.
- Misalign with MEM_DATA_RESP_MISALIGN_EN defined: SW addr 0x21 data 0xFFFFFFFF -> resp_err=1, then LW 0x20 returns the prior contents unchanged. Without the macro -> resp_err=0 and word 0x20 becomes 0xFFFFFFFF.
- Reset mid-WAIT: accept SW addr 0x30 data 0xA5A5A5A5, assert rst_n=0 one cycle later -> outputs return to reset values immediately; a subsequent LW 0x30 does not return 0xA5A5A5A5 (preload the word with 0 first).
